// File: rtl/ctrl_fsm_multiciclo.sv
// ctrl_fsm_multiciclo: multicycle MIPS main control FSM with mem_ready stalls and a sticky illegal-opcode flag.
module ctrl_fsm_multiciclo #(
    parameter bit         USE_MEM_READY = 1'b1,
    parameter logic [5:0] JR_FUNCT      = 6'b001000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       BranchEq,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state_o,
    output logic       illegal_op
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BEQ, S_BNE, S_ADDIEX, S_ADDIWB, S_JUMP, S_JR, S_UNUSED
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   ready;

    assign ready      = USE_MEM_READY ? mem_ready : 1'b1;
    assign state_o    = state_q;
    assign illegal_op = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        PCWrite   = 1'b0;
        BranchEq  = 1'b0;
        BranchNe  = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        MemtoReg  = 1'b0;
        RegDst    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        PCSource  = 2'b00;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = ready;
                PCWrite = ready;
                state_d = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000: state_d = (funct == JR_FUNCT) ? S_JR : S_EXEC;
                    6'b000100: state_d = S_BEQ;
                    6'b000101: state_d = S_BNE;
                    6'b001000: state_d = S_ADDIEX;
                    6'b000010: state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                BranchEq = (state_q == S_BEQ);
                BranchNe = (state_q == S_BNE);
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_JR: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b10;
                PCSource = 2'b11;
                PCWrite  = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
